// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: requester count/index width, FSM state encoding, default
// watchdog limit, and the rotate / one-hot helpers used by the arbiter.
package arb_pkg;

  localparam int ARB_N    = 8;   // number of requesters
  localparam int ARB_IDW  = 3;   // width of a requester index
  localparam int ARB_CNTW = 8;   // watchdog counter width

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Rotate right: result bit i is v[(i + sh) mod ARB_N], so the requester
  // sitting at the priority pointer lands on bit 0.
  function automatic logic [ARB_N-1:0] rotr(input logic [ARB_N-1:0]   v,
                                             input logic [ARB_IDW-1:0] sh);
    logic [2*ARB_N-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[ARB_N-1:0];
  endfunction

  function automatic logic [ARB_N-1:0] id_to_onehot(input logic [ARB_IDW-1:0] id);
    logic [ARB_N-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// 8-to-3 lowest-index-first priority encoder with an "any bit set" flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input vector directly.
//
// Ports:
//   vec_i  [7:0]  input vector to encode
//   idx_o  [2:0]  index of the lowest set bit of vec_i (0 when vec_i == 0)
//   any_o         high when any bit of vec_i is set
module prio_enc_8_3
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   vec_i,
  output logic [ARB_IDW-1:0] idx_o,
  output logic               any_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = ARB_IDW'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter granting one shared single-transaction resource to 8 requesters.
// Latency: grant registered one cycle after req is sampled in IDLE; one idle bubble per handoff.
// Backpressure: grant is locked until res_done (or the optional watchdog) releases it.
//
// Ports:
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   req[7:0]   request vector, bit i = requester i
//   res_done   one-cycle pulse from the resource ending the current transaction
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_id     binary index of the granted requester, zero when idle
//   gnt_valid  high whenever gnt is nonzero
//   ptr        current highest-priority requester index (debug)
//   timeout    one-cycle pulse on a watchdog forced release
//
// Optional feature macro: ARB_TIMEOUT_EN. When defined, an 8-bit watchdog
// forces release after TIMEOUT_CYCLES busy cycles without res_done. When
// undefined, no counter exists, timeout is tied low and a grant is held
// until res_done.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT  // legal 1..255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ARB_N-1:0]   req,
  input  logic               res_done,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid,
  output logic [ARB_IDW-1:0] ptr,
  output logic               timeout
);

  arb_state_e         state_q, state_d;
  logic [ARB_N-1:0]   gnt_q, gnt_d;
  logic [ARB_IDW-1:0] gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ARB_IDW-1:0] ptr_q, ptr_d;

  logic [ARB_N-1:0]   req_rot;
  logic [ARB_IDW-1:0] enc_idx;
  logic               enc_any;
  logic [ARB_IDW-1:0] winner;
  logic               expire;      // watchdog forced release this cycle
  logic               release_w;   // BUSY ends at the coming edge

  // Rotate so the pointer position is bit 0; the lowest set bit of the
  // rotated vector is then the first requester at or after ptr.
  assign req_rot = rotr(req, ptr_q);

  prio_enc_8_3 u_enc (
    .vec_i (req_rot),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Undo the rotation; 3-bit overflow provides the mod-8 wrap.
  assign winner = enc_idx + ptr_q;

`ifdef ARB_TIMEOUT_EN
  localparam logic [ARB_CNTW-1:0] TO_LAST = ARB_CNTW'(TIMEOUT_CYCLES - 1);

  logic [ARB_CNTW-1:0] cnt_q, cnt_d;
  logic                timeout_q;

  // The counter holds the number of completed BUSY cycles; in the
  // TIMEOUT_CYCLES-th BUSY cycle it sits at TIMEOUT_CYCLES-1 and the
  // release lands on that cycle's closing edge. res_done has priority.
  assign expire = (state_q == BUSY) && !res_done && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && !res_done && !expire) begin
      cnt_d = cnt_q + ARB_CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign expire                = 1'b0;
  assign timeout               = 1'b0;
`endif

  assign release_w = (state_q == BUSY) && (res_done || expire);

  // Next-state and register updates. In BUSY nothing but a release may
  // touch the grant, which keeps the outputs free of any req path.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;

    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d     = BUSY;
          gnt_d       = id_to_onehot(winner);
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (release_w) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + ARB_IDW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign ptr       = ptr_q;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(gnt));

  a_valid_match : assert property (@(posedge clk) disable iff (!resetn)
    gnt_valid == (gnt != '0));

  a_id_match : assert property (@(posedge clk) disable iff (!resetn)
    gnt_valid |-> (gnt == id_to_onehot(gnt_id)));

  a_grant_locked : assert property (@(posedge clk) disable iff (!resetn)
    (state_q == BUSY && !release_w) |=> $stable(gnt) && $stable(gnt_id));
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: a per-cycle vector table
// (inputs and expected registered outputs) plus hand sequences for
// asynchronous reset mid-transaction and the optional watchdog.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] req = 8'h00;
  logic       res_done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic [2:0] ptr;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .res_done  (res_done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .ptr       (ptr),
    .timeout   (timeout)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] req_t = 8'h00;
  logic       done_t = 1'b0;
  logic [7:0] gnt_t;
  logic [2:0] gnt_id_t;
  logic       gnt_valid_t;
  logic [2:0] ptr_t;
  logic       timeout_t;

  rr_arbiter_8 #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req_t),
    .res_done  (done_t),
    .gnt       (gnt_t),
    .gnt_id    (gnt_id_t),
    .gnt_valid (gnt_valid_t),
    .ptr       (ptr_t),
    .timeout   (timeout_t)
  );
`endif

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic [2:0] ptr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g,
                     input logic [2:0] id, input logic v, input logic [2:0] p);
    vec_t e;
    e.req = r; e.done = d; e.gnt = g; e.id = id; e.vld = v; e.ptr = p;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [7:0] g, input logic [2:0] id,
                          input logic v, input logic [2:0] p);
    chk({tag, ".gnt"},       32'(gnt),       32'(g));
    chk({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".ptr"},       32'(ptr),       32'(p));
    chk({tag, ".timeout"},   32'(timeout),   32'h0);
  endtask

  initial begin
    logic [7:0] one;
    one = 8'h01;

    // Rotation with all requesting: grants 0..7 then 0, done in first BUSY cycle.
    for (int k = 0; k < 8; k++) begin
      add(8'hFF, 1'b0, one << k, 3'(k), 1'b1, 3'(k));
      add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 3'(k + 1));
    end
    add(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 3'd0);
    add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 3'd1);
    // Move pointer to 3, then pointer skip: from 3 the order reaches 0 before 2.
    add(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 3'd1);
    add(8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 3'd3);
    add(8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 3'd3);
    add(8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 3'd1);
    add(8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 3'd1);
    add(8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 3'd3);
    // Lock: grant 5, drop req[5], raise req[1], no done for 10 cycles.
    add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 3'd3);
    for (int k = 0; k < 10; k++) add(8'h02, 1'b0, 8'h20, 3'd5, 1'b1, 3'd3);
    add(8'h02, 1'b1, 8'h00, 3'd0, 1'b0, 3'd6);
    add(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 3'd6);
    add(8'h02, 1'b1, 8'h00, 3'd0, 1'b0, 3'd2);
    // Spurious done in IDLE.
    for (int k = 0; k < 3; k++) add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 3'd2);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 3'd2);
    // Requester exactly at the pointer wins, then wrap from 7 to 0.
    add(8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 3'd2);
    add(8'h84, 1'b1, 8'h00, 3'd0, 1'b0, 3'd3);
    add(8'h84, 1'b0, 8'h80, 3'd7, 1'b1, 3'd3);
    add(8'h84, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0);

    // Reset with everyone requesting.
    resetn = 1'b0;
    req    = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk_main("reset", 8'h00, 3'd0, 1'b0, 3'd0);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      req      = vecs[i].req;
      res_done = vecs[i].done;
      @(posedge clk);
      #1;
      chk_main($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].id, vecs[i].vld, vecs[i].ptr);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a transaction.
    req = 8'h02; res_done = 1'b0;
    @(posedge clk); #1;
    chk_main("mid.g1", 8'h02, 3'd1, 1'b1, 3'd0);
    @(negedge clk); res_done = 1'b1;
    @(posedge clk); #1;
    chk_main("mid.d1", 8'h00, 3'd0, 1'b0, 3'd2);
    @(negedge clk); req = 8'h08; res_done = 1'b0;
    @(posedge clk); #1;
    chk_main("mid.g3", 8'h08, 3'd3, 1'b1, 3'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk_main("mid.rst", 8'h00, 3'd0, 1'b0, 3'd0);
    @(negedge clk); resetn = 1'b1; req = 8'h00;
    @(posedge clk); #1;
    chk_main("mid.idle", 8'h00, 3'd0, 1'b0, 3'd0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog expiry: grant 2, four BUSY cycles without done.
    @(negedge clk); req_t = 8'h04;
    @(posedge clk); #1;
    chk("to.grant", 32'(gnt_t), 32'h04);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
      chk($sformatf("to.hold%0d.gnt", k), 32'(gnt_t), 32'h04);
      chk($sformatf("to.hold%0d.timeout", k), 32'(timeout_t), 32'h0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    chk("to.exp.timeout", 32'(timeout_t), 32'h1);
    chk("to.exp.gnt", 32'(gnt_t), 32'h00);
    chk("to.exp.ptr", 32'(ptr_t), 32'h3);
    @(negedge clk); req_t = 8'h00;
    @(posedge clk); #1;
    chk("to.pulse_end", 32'(timeout_t), 32'h0);

    // Done coincident with expiry: done wins, no timeout pulse.
    @(negedge clk); req_t = 8'h04;
    @(posedge clk); #1;
    chk("to2.grant", 32'(gnt_id_t), 32'h2);
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk); done_t = 1'b1;
    @(posedge clk); #1;
    chk("to2.timeout", 32'(timeout_t), 32'h0);
    chk("to2.gnt", 32'(gnt_t), 32'h00);
    chk("to2.ptr", 32'(ptr_t), 32'h3);
    @(negedge clk); done_t = 1'b0; req_t = 8'h00;
    @(posedge clk); #1;
    chk("to2.after", 32'(timeout_t), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
